// File: rtl/shreg_pkg.sv
// rtl/shreg_pkg.sv - shared types and defaults for the shreg serial link
package shreg_pkg;

  localparam int SHREG_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/shreg_rx_if.sv
// rtl/shreg_rx_if.sv - serial input and parallel word handshake bundle of shreg_rx
interface shreg_rx_if
  import shreg_pkg::*;
#(
  parameter int WIDTH = SHREG_WIDTH
);

  logic             sin;
  logic             sfr;
  logic             ready;
  logic             ovr_clr;
  logic [WIDTH-1:0] q;
  logic             valid;
  logic             ovr;
  logic             abort;
  logic             busy;

  modport master (
    output sin, sfr, ready, ovr_clr,
    input  q, valid, ovr, abort, busy
  );

  modport slave (
    input  sin, sfr, ready, ovr_clr,
    output q, valid, ovr, abort, busy
  );

endinterface

// File: rtl/shreg_rx_core.sv
// rtl/shreg_rx_core.sv - shift register and bit counter of shreg_rx
// word_o is the register contents with sin_i already shifted in, i.e. the full word on the last bit.
module shreg_rx_core
  import shreg_pkg::*;
#(
  parameter int WIDTH     = SHREG_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin_i,
  input  logic             start_i,
  input  logic             shift_i,
  input  logic             clr_i,
  output logic             last_o,
  output logic [WIDTH-1:0] word_o
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] sr_q, sr_d, shifted, first;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    if (MSB_FIRST) begin
      shifted = {sr_q[WIDTH-2:0], sin_i};
      first   = {{(WIDTH-1){1'b0}}, sin_i};
    end else begin
      shifted = {sin_i, sr_q[WIDTH-1:1]};
      first   = {sin_i, {(WIDTH-1){1'b0}}};
    end
  end

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (start_i) begin
      sr_d  = first;
      cnt_d = CW'(1);
    end else if (clr_i) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (shift_i) begin
      sr_d  = shifted;
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CW'(WIDTH - 1));
  assign word_o = shifted;

endmodule

// File: rtl/shreg_rx.sv
// rtl/shreg_rx.sv - serial-in/parallel-out receiver with valid/ready output, overrun and abort flags
module shreg_rx
  import shreg_pkg::*;
#(
  parameter int WIDTH     = SHREG_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  shreg_rx_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             abort_q, abort_d;
  logic             core_start, core_shift, core_clr, core_last;
  logic [WIDTH-1:0] core_word;

  shreg_rx_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .sin_i   (bus.sin),
    .start_i (core_start),
    .shift_i (core_shift),
    .clr_i   (core_clr),
    .last_o  (core_last),
    .word_o  (core_word)
  );

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    valid_d    = valid_q;
    ovr_d      = ovr_q;
    abort_d    = 1'b0;
    core_start = 1'b0;
    core_shift = 1'b0;
    core_clr   = 1'b0;
    if (valid_q && bus.ready) valid_d = 1'b0;
    if (bus.ovr_clr) ovr_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.sfr) begin
          core_start = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        // A new strobe mid-frame restarts the frame with sin as its bit 0.
        if (bus.sfr) begin
          core_start = 1'b1;
          abort_d    = 1'b1;
        end else if (core_last) begin
          core_clr = 1'b1;
          word_d   = core_word;
          valid_d  = 1'b1;
          if (valid_q && !bus.ready) ovr_d = 1'b1;
          state_d  = IDLE;
        end else begin
          core_shift = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      abort_q <= abort_d;
    end
  end

  assign bus.q     = word_q;
  assign bus.valid = valid_q;
  assign bus.ovr   = ovr_q;
  assign bus.abort = abort_q;
  assign bus.busy  = (state_q == SHIFT);

endmodule

// File: tb/tb_shreg_rx.sv
// tb/tb_shreg_rx.sv - self-checking bench for shreg_rx, MSB-first and LSB-first instances side by side
module tb_shreg_rx;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic sin, sfr, ready, ovr_clr;
  int   n_cmp = 0;
  int   n_bad = 0;

  shreg_rx_if #(.WIDTH(W)) bus_m ();
  shreg_rx_if #(.WIDTH(W)) bus_l ();

  assign bus_m.sin = sin;
  assign bus_m.sfr = sfr;
  assign bus_m.ready = ready;
  assign bus_m.ovr_clr = ovr_clr;
  assign bus_l.sin = sin;
  assign bus_l.sfr = sfr;
  assign bus_l.ready = ready;
  assign bus_l.ovr_clr = ovr_clr;

  shreg_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(bus_m));
  shreg_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst_n(rst_n), .bus(bus_l));

  always #5 clk = ~clk;

  // Reference model: received bits kept as a list, words assembled by bit position.
  bit         m_in;
  bit         m_bits[$];
  logic [W-1:0] m_qm, m_ql;
  bit         m_valid, m_ovr, m_abort;

  wire [2*W+9:0] obs = {bus_m.q, bus_l.q, bus_m.valid, bus_l.valid, bus_m.ovr, bus_l.ovr,
                        bus_m.abort, bus_l.abort, bus_m.busy, bus_l.busy};

  function automatic logic [2*W+9:0] model_vec();
    return {m_qm, m_ql, m_valid, m_valid, m_ovr, m_ovr, m_abort, m_abort, m_in, m_in};
  endfunction

  task automatic model_reset();
    m_in = 0; m_bits.delete(); m_qm = '0; m_ql = '0;
    m_valid = 0; m_ovr = 0; m_abort = 0;
  endtask

  task automatic model_edge();
    bit old_valid;
    bit done;
    old_valid = m_valid;
    done = 0;
    m_abort = 0;
    if (ovr_clr) m_ovr = 0;
    if (old_valid && ready) m_valid = 0;
    if (sfr) begin
      if (m_in) m_abort = 1;
      m_bits.delete();
      m_bits.push_back(sin);
      m_in = 1;
    end else if (m_in) begin
      m_bits.push_back(sin);
      if (m_bits.size() == W) done = 1;
    end
    if (done) begin
      for (int i = 0; i < W; i++) begin
        m_qm[W-1-i] = m_bits[i];
        m_ql[i] = m_bits[i];
      end
      m_valid = 1;
      if (old_valid && !ready) m_ovr = 1;
      m_in = 0;
      m_bits.delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send_bit(input logic s, input logic f);
    sin = s; sfr = f;
    tick();
    sfr = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) send_bit(w[i], i == W - 1);
  endtask

  task automatic consume();
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sin = 0; sfr = 0; ready = 0; ovr_clr = 0;
    model_reset();
    #2;
    n_cmp++;
    if (obs !== '0) begin
      n_bad++; $display("FAIL reset_outputs got %h want 0", obs);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_frame();
    send_bit(1'b0, 1'b1);
    n_cmp++;
    if ({bus_m.busy, bus_m.valid} !== 2'b10) begin
      n_bad++; $display("FAIL frame_start busy/valid got %b want 10", {bus_m.busy, bus_m.valid});
    end
    for (int i = 1; i < W; i++) begin
      send_bit(1'b1, 1'b0);
      if (i == W - 2) begin
        n_cmp++;
        if (bus_m.valid !== 1'b0) begin
          n_bad++; $display("FAIL frame_early_valid got %b want 0", bus_m.valid);
        end
      end
    end
    n_cmp++;
    if ({bus_m.q, bus_l.q, bus_m.valid, bus_l.valid} !== {8'h7F, 8'hFE, 2'b11}) begin
      n_bad++; $display("FAIL frame_word got %h/%h v=%b%b want 7f/fe v=11",
                        bus_m.q, bus_l.q, bus_m.valid, bus_l.valid);
    end
    sin = 1'b0;
    tick(); tick();
    n_cmp++;
    if (bus_m.valid !== 1'b1 || bus_m.q !== 8'h7F) begin
      n_bad++; $display("FAIL frame_hold got v=%b q=%h want v=1 q=7f", bus_m.valid, bus_m.q);
    end
    consume();
    n_cmp++;
    if ({bus_m.valid, bus_l.valid, bus_m.ovr, bus_m.abort} !== 4'b0000) begin
      n_bad++; $display("FAIL frame_consume got %b want 0000",
                        {bus_m.valid, bus_l.valid, bus_m.ovr, bus_m.abort});
    end
  endtask

  task automatic test_back_to_back();
    send_word(8'hA5);
    n_cmp++;
    if ({bus_m.q, bus_m.valid, bus_m.ovr} !== {8'hA5, 2'b10}) begin
      n_bad++; $display("FAIL b2b_first got q=%h v=%b o=%b want a5 1 0", bus_m.q, bus_m.valid, bus_m.ovr);
    end
    send_word(8'h3C);
    n_cmp++;
    if ({bus_m.q, bus_l.q, bus_m.valid, bus_m.ovr, bus_l.ovr} !== {8'h3C, 8'h3C, 3'b111}) begin
      n_bad++; $display("FAIL b2b_overrun got %h %h v=%b o=%b%b want 3c 3c 1 11",
                        bus_m.q, bus_l.q, bus_m.valid, bus_m.ovr, bus_l.ovr);
    end
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    n_cmp++;
    if ({bus_m.ovr, bus_l.ovr, bus_m.valid} !== 3'b001) begin
      n_bad++; $display("FAIL b2b_ovr_clr got %b want 001", {bus_m.ovr, bus_l.ovr, bus_m.valid});
    end
    consume();
  endtask

  task automatic test_same_edge();
    logic [W-1:0] w;
    send_word(8'hA5);
    w = 8'h3C;
    for (int i = W - 1; i >= 0; i--) begin
      if (i == 0) ready = 1'b1;
      send_bit(w[i], i == W - 1);
      ready = 1'b0;
    end
    n_cmp++;
    if ({bus_m.q, bus_m.valid, bus_m.ovr, bus_l.ovr} !== {8'h3C, 3'b100}) begin
      n_bad++; $display("FAIL same_edge got q=%h v=%b o=%b%b want 3c 1 00",
                        bus_m.q, bus_m.valid, bus_m.ovr, bus_l.ovr);
    end
    consume();
  endtask

  task automatic test_abort();
    logic [W-1:0] p, w;
    bit saw_valid;
    p = 8'h5A; w = 8'hC3; saw_valid = 0;
    for (int i = W - 1; i >= W - 4; i--) send_bit(p[i], i == W - 1);
    send_bit(w[W-1], 1'b1);
    n_cmp++;
    if ({bus_m.abort, bus_l.abort, bus_m.busy, bus_m.valid} !== 4'b1110) begin
      n_bad++; $display("FAIL abort_pulse got %b want 1110",
                        {bus_m.abort, bus_l.abort, bus_m.busy, bus_m.valid});
    end
    for (int i = W - 2; i >= 0; i--) begin
      send_bit(w[i], 1'b0);
      if (i == W - 2) begin
        n_cmp++;
        if (bus_m.abort !== 1'b0) begin
          n_bad++; $display("FAIL abort_one_cycle got %b want 0", bus_m.abort);
        end
      end
      if (i > 0 && bus_m.valid) saw_valid = 1;
    end
    n_cmp++;
    if ({saw_valid, bus_m.q, bus_l.q, bus_m.valid} !== {1'b0, 8'hC3, 8'hC3, 1'b1}) begin
      n_bad++; $display("FAIL abort_restart got early=%b q=%h/%h v=%b want 0 c3/c3 1",
                        saw_valid, bus_m.q, bus_l.q, bus_m.valid);
    end
    consume();
  endtask

  task automatic test_midreset();
    bit saw_valid;
    saw_valid = 0;
    send_word(8'h96);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(1)), i == 0);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== '0) begin
      n_bad++; $display("FAIL midreset_async got %h want 0", obs);
    end
    #2 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      send_bit(1'(i % 2), 1'b0);
      if (bus_m.valid || bus_l.valid || bus_m.busy) saw_valid = 1;
    end
    n_cmp++;
    if (saw_valid !== 1'b0) begin
      n_bad++; $display("FAIL midreset_unframed got activity=%b want 0", saw_valid);
    end
    send_word(8'h81);
    n_cmp++;
    if ({bus_m.q, bus_l.q, bus_m.valid, bus_m.ovr} !== {8'h81, 8'h81, 2'b10}) begin
      n_bad++; $display("FAIL midreset_next got %h %h v=%b o=%b want 81 81 1 0",
                        bus_m.q, bus_l.q, bus_m.valid, bus_m.ovr);
    end
    consume();
  endtask

  task automatic test_random();
    n_cmp++;
    if (obs !== model_vec()) begin
      n_bad++; $display("FAIL random_sync got %h want %h", obs, model_vec());
    end
    for (int c = 0; c < 600; c++) begin
      sin = 1'($urandom_range(1));
      sfr = m_in ? ($urandom_range(9) == 0) : ($urandom_range(2) == 0);
      if (m_in && m_bits.size() == W - 1) sfr = 1'b0;
      ready = ($urandom_range(2) == 0);
      ovr_clr = ($urandom_range(7) == 0);
      tick();
      n_cmp++;
      if (obs !== model_vec()) begin
        n_bad++; $display("FAIL random_cycle%0d got %h want %h", c, obs, model_vec());
      end
    end
    sfr = 0; ready = 0; ovr_clr = 0;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_same_edge();
    test_abort();
    test_midreset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
